// File: rtl/car_pkg.sv
// Shared types and helpers for the elevator car motion controller.
package car_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } car_state_t;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_EQ = 2'd0;
  localparam dir_t DIR_UP = 2'd1;
  localparam dir_t DIR_DN = 2'd2;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/floor_dir_cmp.sv
// Unsigned floor comparator: reports whether the target lies above, below or at the reference floor.
module floor_dir_cmp
  import car_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W:1] target,
  input  logic [W:1] cur_floor,
  output dir_t       dir
);

  always_comb begin
    dir = DIR_EQ;
    if (target > cur_floor) begin
      dir = DIR_UP;
    end else if (target < cur_floor) begin
      dir = DIR_DN;
    end
  end

endmodule

// File: rtl/car_motion_ctrl.sv
// Elevator car motion controller: accepts one target floor, steps the car one floor per travel
// interval, then dwells with the door open. Optional macro CAR_DOOR_HOLD_EN adds the door_hold input.
module car_motion_ctrl
  import car_pkg::*;
#(
  parameter int FLOOR_W    = 4,
  parameter int NUM_FLOORS = 16,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  input  logic [FLOOR_W:1] req_floor,
`ifdef CAR_DOOR_HOLD_EN
  input  logic           door_hold,
`endif
  output logic           req_ready,
  output logic [FLOOR_W:1] cur_floor,
  output logic           moving_up,
  output logic           moving_down,
  output logic           door_open,
  output logic           arrived,
  output logic           busy
);

  localparam int TW = clog2((TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC);
  localparam logic [TW-1:0]    TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0]    DOOR_LAST   = TW'(DOOR_CYC - 1);
  localparam logic [TW-1:0]    TIMER_ONE   = TW'(1);
  localparam logic [FLOOR_W:1] FLOOR_ONE   = FLOOR_W'(1);
  localparam logic [FLOOR_W:1] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  car_state_t       state, state_d;
  logic [FLOOR_W:1] floor_q, floor_d;
  logic [FLOOR_W:1] target_q, target_d;
  logic [FLOOR_W:1] step_floor, cmp_a, cmp_b;
  logic [TW-1:0]    timer, timer_d;
  logic             arrived_q, arrived_d;
  logic             hold;
  dir_t             dir;

`ifdef CAR_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // The single comparator serves the accept decision in IDLE and the arrival check while moving.
  always_comb begin
    step_floor = floor_q;
    if (state == MOVE_UP) begin
      step_floor = floor_q + FLOOR_ONE;
    end else if (state == MOVE_DOWN) begin
      step_floor = floor_q - FLOOR_ONE;
    end
    cmp_a = (state == IDLE) ? req_floor : target_q;
    cmp_b = (state == IDLE) ? floor_q : step_floor;
  end

  floor_dir_cmp #(.W(FLOOR_W)) u_cmp (
    .target   (cmp_a),
    .cur_floor(cmp_b),
    .dir      (dir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      floor_q   <= '0;
      target_q  <= '0;
      timer     <= '0;
      arrived_q <= 1'b0;
    end else begin
      state     <= state_d;
      floor_q   <= floor_d;
      target_q  <= target_d;
      timer     <= timer_d;
      arrived_q <= arrived_d;
    end
  end

  always_comb begin
    state_d   = state;
    floor_d   = floor_q;
    target_d  = target_q;
    timer_d   = timer + TIMER_ONE;
    arrived_d = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (req_valid) begin
          target_d = req_floor;
          // Out-of-range targets are consumed here and never reach the motion states.
          if (int'(req_floor) < NUM_FLOORS) begin
            case (dir)
              DIR_UP:  state_d = MOVE_UP;
              DIR_DN:  state_d = MOVE_DOWN;
              default: begin
                state_d   = DOOR_OPEN;
                arrived_d = 1'b1;
              end
            endcase
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer == TRAVEL_LAST) begin
          timer_d = '0;
          if ((state == MOVE_UP && floor_q == TOP_FLOOR) ||
              (state == MOVE_DOWN && floor_q == '0)) begin
            state_d = IDLE;
          end else begin
            floor_d = step_floor;
            if (dir == DIR_EQ) begin
              state_d   = DOOR_OPEN;
              arrived_d = 1'b1;
            end
          end
        end
      end
      DOOR_OPEN: begin
        if (hold) begin
          timer_d = '0;
        end else if (timer == DOOR_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign moving_up   = (state == MOVE_UP);
  assign moving_down = (state == MOVE_DOWN);
  assign door_open   = (state == DOOR_OPEN);
  assign busy        = (state != IDLE);
  assign arrived     = arrived_q;
  assign cur_floor   = floor_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Scoreboard bench for car_motion_ctrl: each accepted trip is queued with its expected timeline
// and a negedge monitor compares the car outputs against it every cycle.
module tb_car_motion_ctrl;

  localparam int FW       = 5;
  localparam int NF       = 16;
  localparam int TC       = 8;
  localparam int DC       = 16;
  localparam int HOLD_LEN = 40;

  typedef struct {
    int target;
    int start;
    int c0;
    int door_len;
  } trip_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW:1]   req_floor = '0;
  logic          door_hold = 1'b0;
  logic          req_ready, moving_up, moving_down, door_open, arrived, busy;
  logic [FW:1]   cur_floor;

  trip_t q[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    model_floor = 0;

  car_motion_ctrl #(
    .FLOOR_W   (FW),
    .NUM_FLOORS(NF),
    .TRAVEL_CYC(TC),
    .DOOR_CYC  (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_floor  (req_floor),
`ifdef CAR_DOOR_HOLD_EN
    .door_hold  (door_hold),
`endif
    .req_ready  (req_ready),
    .cur_floor  (cur_floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .arrived    (arrived),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected position is start +/- elapsed whole travel intervals, capped at the trip length.
  trip_t t;
  int    n, d, k, travel, exp_floor;
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() == 0) begin
        checkOutput("idle_ready", int'(req_ready), 1);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_up", int'(moving_up), 0);
        checkOutput("idle_down", int'(moving_down), 0);
        checkOutput("idle_door", int'(door_open), 0);
        checkOutput("idle_arrived", int'(arrived), 0);
        checkOutput("idle_floor", int'(cur_floor), model_floor);
      end else begin
        t = q[0];
        n = (t.target > t.start) ? t.target - t.start : t.start - t.target;
        d = cyc - t.c0;
        k = d / TC;
        if (k > n) k = n;
        exp_floor = (t.target >= t.start) ? t.start + k : t.start - k;
        travel = n * TC;
        checkOutput("trip_floor", int'(cur_floor), exp_floor);
        checkOutput("trip_up", int'(moving_up), int'(d < travel && t.target > t.start));
        checkOutput("trip_down", int'(moving_down), int'(d < travel && t.target < t.start));
        checkOutput("trip_door", int'(door_open), int'(d >= travel && d < travel + t.door_len));
        checkOutput("trip_arrived", int'(arrived), int'(d == travel));
        checkOutput("trip_busy", int'(busy), 1);
        checkOutput("trip_ready", int'(req_ready), 0);
        if (d >= travel + t.door_len - 1) void'(q.pop_front());
      end
    end
  end

  task automatic waitIdle();
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(q.size() == 0 && req_ready === 1'b1) && waited < 2000);
    if (waited >= 2000) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got busy expected idle within 2000 cycles");
    end
  endtask

  task automatic applyStimulus(input int floor, input int door_len);
    waitIdle();
    req_floor = FW'(floor);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (floor < NF) begin
      q.push_back('{floor, model_floor, cyc, door_len});
      model_floor = floor;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int f;
    int waited;
    #1;
    checkOutput("rst_ready", int'(req_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_floor", int'(cur_floor), 0);
    checkOutput("rst_up", int'(moving_up), 0);
    checkOutput("rst_down", int'(moving_down), 0);
    checkOutput("rst_door", int'(door_open), 0);
    checkOutput("rst_arrived", int'(arrived), 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3, DC);
    applyStimulus(0, DC);
    applyStimulus(5, DC);
    applyStimulus(5, DC);
    applyStimulus(20, DC);
    applyStimulus(31, DC);
    applyStimulus(15, DC);
    applyStimulus(16, DC);
    applyStimulus(0, DC);

    repeat (16) begin
      if ($urandom_range(0, 3) == 0) f = int'($urandom_range(NF, 31));
      else f = int'($urandom_range(0, NF - 1));
      applyStimulus(f, DC);
    end

`ifdef CAR_DOOR_HOLD_EN
    applyStimulus((model_floor == 4) ? 6 : 4, HOLD_LEN + DC);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (arrived !== 1'b1 && waited < 500);
    checkOutput("hold_arrival_seen", int'(arrived), 1);
    door_hold = 1'b1;
    repeat (HOLD_LEN) @(negedge clk);
    door_hold = 1'b0;
`endif

    // A request held while the car travels must not disturb the trip; reset then aborts it.
    applyStimulus((model_floor < 8) ? 15 : 0, DC);
    repeat (20) @(negedge clk);
    req_floor = FW'(7);
    req_valid = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("busy_hold_ready", int'(req_ready), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    model_floor = 0;
    #1;
    checkOutput("async_rst_floor", int'(cur_floor), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_ready", int'(req_ready), 1);
    checkOutput("async_rst_up", int'(moving_up), 0);
    checkOutput("async_rst_down", int'(moving_down), 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2, DC);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
